// File: rtl/ahb_lite_single_master.sv
// AHB-Lite initiator: valid/ready requests become single NONSEQ transfers, one response each.
// Optional macro AHB_MASTER_PIPELINE_EN overlaps the next address phase with the current data phase.
module ahb_lite_single_master #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [HADDR_SIZE-1:0] req_addr,
  input  logic                  req_write,
  input  logic [2:0]            req_size,
  input  logic [HDATA_SIZE-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [HDATA_SIZE-1:0] rsp_rdata,
  output logic [HADDR_SIZE-1:0] HADDR,
  output logic                  HWRITE,
  output logic [2:0]            HSIZE,
  output logic [2:0]            HBURST,
  output logic [3:0]            HPROT,
  output logic                  HMASTLOCK,
  output logic [1:0]            HTRANS,
  output logic [HDATA_SIZE-1:0] HWDATA,
  input  logic [HDATA_SIZE-1:0] HRDATA,
  input  logic                  HREADY,
  input  logic                  HRESP
);

  localparam logic [2:0] MAXSZ = 3'($clog2(HDATA_SIZE / 8));
  localparam logic [1:0] HT_IDLE = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

`ifdef AHB_MASTER_PIPELINE_EN
  localparam logic LP_PIPE = 1'b1;
`else
  localparam logic LP_PIPE = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_ERR2
  } state_t;

  state_t                r_state, w_state;
  logic [1:0]            r_htrans, w_htrans;
  logic [HADDR_SIZE-1:0] r_haddr, w_haddr;
  logic                  r_hwrite, w_hwrite;
  logic [2:0]            r_hsize, w_hsize;
  logic [HDATA_SIZE-1:0] r_hwdata, w_hwdata;
  logic [HDATA_SIZE-1:0] r_wdata, w_wdata;
  logic                  r_dwr, w_dwr;
  logic                  r_apend, w_apend;
  logic                  r_rejp, w_rejp;
  logic                  r_rsp_valid, w_rsp_valid;
  logic                  r_rsp_err, w_rsp_err;
  logic [HDATA_SIZE-1:0] r_rsp_rdata, w_rsp_rdata;

  logic [HADDR_SIZE-1:0] w_mask;
  logic                  w_reject;
  logic                  w_ready;
  logic                  w_accept;

  assign w_mask = ~({HADDR_SIZE{1'b1}} << req_size);
  assign w_reject = (req_size > MAXSZ) ||
                    ((req_addr & w_mask) != '0);

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state     <= S_IDLE;
      r_htrans    <= HT_IDLE;
      r_haddr     <= '0;
      r_hwrite    <= 1'b0;
      r_hsize     <= '0;
      r_hwdata    <= '0;
      r_wdata     <= '0;
      r_dwr       <= 1'b0;
      r_apend     <= 1'b0;
      r_rejp      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state;
      r_htrans    <= w_htrans;
      r_haddr     <= w_haddr;
      r_hwrite    <= w_hwrite;
      r_hsize     <= w_hsize;
      r_hwdata    <= w_hwdata;
      r_wdata     <= w_wdata;
      r_dwr       <= w_dwr;
      r_apend     <= w_apend;
      r_rejp      <= w_rejp;
      r_rsp_valid <= w_rsp_valid;
      r_rsp_err   <= w_rsp_err;
      r_rsp_rdata <= w_rsp_rdata;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_htrans    = r_htrans;
    w_haddr     = r_haddr;
    w_hwrite    = r_hwrite;
    w_hsize     = r_hsize;
    w_hwdata    = r_hwdata;
    w_wdata     = r_wdata;
    w_dwr       = r_dwr;
    w_apend     = r_apend;
    w_rejp      = r_rejp;
    w_rsp_valid = 1'b0;
    w_rsp_err   = 1'b0;
    w_rsp_rdata = '0;
    w_ready     = 1'b0;
    w_accept    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        // a reject queued behind a bus transfer is reported here
        if (r_rejp) begin
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_rejp      = 1'b0;
        end else begin
          w_ready = 1'b1;
        end
      end
      S_ADDR: begin
        w_ready = LP_PIPE & HREADY & ~r_rejp;
        if (HREADY) begin
          w_state  = S_DATA;
          w_htrans = HT_IDLE;
          w_hwdata = r_wdata;
          w_dwr    = r_hwrite;
        end
      end
      S_DATA: begin
        w_ready = LP_PIPE & HREADY & ~HRESP & ~r_rejp;
        if (HRESP) begin
          w_htrans = HT_IDLE;
          if (HREADY) begin
            w_rsp_valid = 1'b1;
            w_rsp_err   = 1'b1;
            w_state     = r_apend ? S_ADDR : S_IDLE;
            w_htrans    = r_apend ? HT_NONSEQ : HT_IDLE;
            w_apend     = 1'b0;
          end else begin
            w_state = S_ERR2;
          end
        end else if (HREADY) begin
          w_rsp_valid = 1'b1;
          w_rsp_rdata = r_dwr ? '0 : HRDATA;
          if (r_apend) begin
            w_hwdata = r_wdata;
            w_dwr    = r_hwrite;
            w_htrans = HT_IDLE;
            w_apend  = 1'b0;
          end else begin
            w_state = S_IDLE;
          end
        end
      end
      S_ERR2: begin
        // held pipelined request is re-issued once the error retires
        if (HREADY) begin
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
          w_state     = r_apend ? S_ADDR : S_IDLE;
          w_htrans    = r_apend ? HT_NONSEQ : HT_IDLE;
          w_apend     = 1'b0;
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_ready  = w_ready & ~HRESET;
    w_accept = req_valid & w_ready;

    if (w_accept) begin
      if (w_reject) begin
        if (r_state == S_IDLE) begin
          w_rsp_valid = 1'b1;
          w_rsp_err   = 1'b1;
        end else begin
          w_rejp = 1'b1;
        end
      end else begin
        w_htrans = HT_NONSEQ;
        w_haddr  = req_addr;
        w_hwrite = req_write;
        w_hsize  = req_size;
        w_wdata  = req_wdata;
        if (w_state == S_IDLE) begin
          w_state = S_ADDR;
        end else begin
          w_apend = 1'b1;
        end
      end
    end
  end

  assign req_ready = w_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;
  assign HADDR     = r_haddr;
  assign HWRITE    = r_hwrite;
  assign HSIZE     = r_hsize;
  assign HTRANS    = r_htrans;
  assign HWDATA    = r_hwdata;
  assign HBURST    = 3'b000;
  assign HPROT     = 4'b0011;
  assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_lite_single_master.sv
// Scoreboard bench for ahb_lite_single_master: stimulus pushes expected responses,
// a monitor pops and compares each rsp_valid strobe including its arrival cycle.
module tb_ahb_lite_single_master;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic        HMASTLOCK;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;

  ahb_lite_single_master #(
    .HADDR_SIZE(32),
    .HDATA_SIZE(32)
  ) dut (
    .HCLK(HCLK),
    .HRESET(HRESET),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_write(req_write),
    .req_size(req_size),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata),
    .HADDR(HADDR),
    .HWRITE(HWRITE),
    .HSIZE(HSIZE),
    .HBURST(HBURST),
    .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK),
    .HTRANS(HTRANS),
    .HWDATA(HWDATA),
    .HRDATA(HRDATA),
    .HREADY(HREADY),
    .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   n_tests = 0;
  int   n_fail = 0;
  int   acc;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge HCLK) begin
    if (cyc > 0 && rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rsp: got rsp at cycle %0d expected none", cyc);
      end else begin
        m_e = q.pop_front();
        chk("rsp_err", 64'(rsp_err), 64'(m_e.err));
        chk("rsp_rdata", 64'(rsp_rdata), 64'(m_e.rdata));
        chk("rsp_cycle", 64'(cyc), 64'(m_e.due));
      end
    end
  end

  // lat < 0: no response expected
  task automatic send(input logic [31:0] a, input logic w,
                      input logic [2:0] s, input logic [31:0] wd,
                      input logic e, input logic [31:0] rd,
                      input int lat, output int acc_o);
    req_addr  = a;
    req_write = w;
    req_size  = s;
    req_wdata = wd;
    req_valid = 1'b1;
    acc_o = -1;
    for (int i = 0; i < 20 && acc_o < 0; i++) begin
      #1;
      if (req_ready) begin
        acc_o = cyc + 1;
        if (lat >= 0) q.push_back('{e, rd, acc_o + lat});
      end
      @(negedge HCLK);
    end
    req_valid = 1'b0;
    if (acc_o < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: got no req_ready expected accept, addr %h", a);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge HCLK);
  endtask

`ifdef AHB_MASTER_PIPELINE_EN
  task automatic pipe(input bit err);
    int r;
    int a;
    int k;
    r = 0;
    a = cyc + 1;
    if (!err) begin
      for (int i = 0; i < 4; i++)
        q.push_back('{1'b0, 32'hA000_0001 + 32'(i), a + 2 + i});
    end else begin
      q.push_back('{1'b0, 32'hB000_0001, a + 2});
      q.push_back('{1'b1, 32'h0, a + 4});
      q.push_back('{1'b0, 32'hB000_0005, a + 6});
      q.push_back('{1'b0, 32'hB000_0006, a + 7});
    end
    for (int j = 0; j < 12; j++) begin
      k = cyc - a;
      if (!err && k >= 0 && k < 4) begin
        chk("pipe_nonseq", 64'(HTRANS), 64'(2'b10));
        chk("pipe_haddr", 64'(HADDR), 64'(32'h6000 + 32'(4 * k)));
      end
      if (!err && k == 4) chk("pipe_idle", 64'(HTRANS), 64'(2'b00));
      if (err && k == 3) chk("pipe_err2_idle", 64'(HTRANS), 64'(2'b00));
      if (err && k == 4) begin
        chk("pipe_reissue", 64'(HTRANS), 64'(2'b10));
        chk("pipe_reissue_addr", 64'(HADDR), 64'(32'h6008));
      end
      HRDATA = (err ? 32'hB000_0000 : 32'hA000_0000) + 32'(k);
      HREADY = !(err && k == 2);
      HRESP  = err && (k == 2 || k == 3);
      req_valid = (r < 4);
      req_addr  = 32'h6000 + 32'(4 * r);
      req_write = 1'b0;
      req_size  = 3'd2;
      #1;
      if (req_valid && req_ready) r++;
      @(negedge HCLK);
    end
    req_valid = 1'b0;
    HREADY = 1'b1;
    HRESP = 1'b0;
    chk("pipe_accepted", 64'(r), 64'd4);
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    HRESET    = 1'b1;
    req_valid = 1'b1;
    req_addr  = 32'h0;
    req_write = 1'b0;
    req_size  = 3'd2;
    req_wdata = 32'h0;
    HRDATA    = 32'h0;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    tick(3);

    // reset state
    #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    chk("rst_htrans", 64'(HTRANS), 64'd0);
    chk("rst_haddr", 64'(HADDR), 64'd0);
    chk("rst_hwdata", 64'(HWDATA), 64'd0);
    chk("rst_hsize", 64'(HSIZE), 64'd0);
    chk("rst_hwrite", 64'(HWRITE), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("hburst", 64'(HBURST), 64'd0);
    chk("hprot", 64'(HPROT), 64'h3);
    chk("hmastlock", 64'(HMASTLOCK), 64'd0);
    tick(1);
    HRESET    = 1'b0;
    req_valid = 1'b0;
    tick(1);

    // 1: zero-wait read
    HRDATA = 32'hCAFE_F00D;
    send(32'h1000, 1'b0, 3'd2, 32'h0, 1'b0, 32'hCAFE_F00D, 2, acc);
    chk("t1_nonseq", 64'(HTRANS), 64'(2'b10));
    chk("t1_haddr", 64'(HADDR), 64'h1000);
    chk("t1_hsize", 64'(HSIZE), 64'd2);
    chk("t1_hwrite", 64'(HWRITE), 64'd0);
    tick(1);
    chk("t1_idle", 64'(HTRANS), 64'(2'b00));
    tick(3);

    // 2: write with three data-phase wait states
    send(32'h2004, 1'b1, 3'd2, 32'h1234_5678, 1'b0, 32'h0, 5, acc);
    chk("t2_hwrite", 64'(HWRITE), 64'd1);
    chk("t2_nonseq", 64'(HTRANS), 64'(2'b10));
    for (int i = 0; i < 4; i++) begin
      @(negedge HCLK);
      chk("t2_hwdata", 64'(HWDATA), 64'h1234_5678);
      HREADY = (i == 3);
      if (i == 1) begin
        #1;
        chk("t2_busy_ready", 64'(req_ready), 64'd0);
      end
    end
    tick(3);

    // 3: two-cycle ERROR on read
    HRDATA = 32'hFFFF_FFFF;
    send(32'h3000, 1'b0, 3'd2, 32'h0, 1'b1, 32'h0, 3, acc);
    tick(1);
    HREADY = 1'b0;
    HRESP  = 1'b1;
    tick(1);
    chk("t3_err2_idle", 64'(HTRANS), 64'(2'b00));
    HREADY = 1'b1;
    tick(1);
    HRESP = 1'b0;
    tick(3);

    // 4: local rejects, then legal narrow reads
    send(32'h1002, 1'b1, 3'd2, 32'hDEAD_BEEF, 1'b1, 32'h0, 0, acc);
    chk("t4_mis_idle", 64'(HTRANS), 64'(2'b00));
    send(32'h1000, 1'b0, 3'd3, 32'h0, 1'b1, 32'h0, 0, acc);
    chk("t4_big_idle", 64'(HTRANS), 64'(2'b00));
    tick(1);
    chk("t4_still_idle", 64'(HTRANS), 64'(2'b00));
    HRDATA = 32'h5A5A_1234;
    send(32'h1002, 1'b0, 3'd1, 32'h0, 1'b0, 32'h5A5A_1234, 2, acc);
    chk("t4_half_nonseq", 64'(HTRANS), 64'(2'b10));
    tick(3);
    HRDATA = 32'h7700_0000;
    send(32'h1003, 1'b0, 3'd0, 32'h0, 1'b0, 32'h7700_0000, 2, acc);
    tick(4);

    // 5: reset during a data-phase wait
    send(32'h4000, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0, -1, acc);
    tick(1);
    HREADY = 1'b0;
    tick(1);
    HRESET = 1'b1;
    #1;
    chk("t5_rst_ready", 64'(req_ready), 64'd0);
    tick(1);
    chk("t5_htrans", 64'(HTRANS), 64'(2'b00));
    chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
    HRESET = 1'b0;
    HREADY = 1'b1;
    tick(1);
    HRDATA = 32'h0BAD_BEEF;
    send(32'h5000, 1'b0, 3'd2, 32'h0, 1'b0, 32'h0BAD_BEEF, 2, acc);
    chk("t5_nonseq", 64'(HTRANS), 64'(2'b10));
    tick(4);

`ifdef AHB_MASTER_PIPELINE_EN
    // 6: back-to-back reads, then ERROR on the second
    pipe(1'b0);
    tick(2);
    pipe(1'b1);
    tick(2);
`endif

    chk("sb_drained", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
